// File: rtl/vid_pkg.sv
// Shared constants and FSM encoding for the vertex-ID pack writer.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package vid_pkg;

  localparam int VID_BW_DEF     = 16;
  localparam int Q_DEF          = 16;
  localparam int ADDR_SPACE_DEF = 4;
  localparam int NUM_ROWS_DEF   = 16;

  // Invalid-vertex sentinel at the default ID width; the read side skips lanes holding it.
  localparam logic [VID_BW_DEF-1:0] VID_PAD = '1;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } wr_state_t;

endpackage

// File: rtl/vid_row_packer.sv
// Packs Q vertex IDs into one row; emits the merged row and a commit strobe on the filling transfer.
// Latency: row/commit are combinational off the accepting transfer; buffer clears on that same edge.
// Backpressure: none of its own; the caller gates transfers with fire.
// Build option VID_PACK_PAD_EN: unfilled lanes hold all-ones instead of zero.
module vid_row_packer
  import vid_pkg::*;
#(
  parameter int Q      = Q_DEF,
  parameter int VID_BW = VID_BW_DEF
) (
  input  logic                en_clk_unused_guard_n,
  input  logic                clk,
  input  logic                rst,
  input  logic                fire,
  input  logic [VID_BW-1:0]   in_vid,
  input  logic                in_last,
  output logic [VID_BW*Q-1:0] row,
  output logic                commit
);

  localparam int LANE_W = (Q > 1) ? $clog2(Q) : 1;

`ifdef VID_PACK_PAD_EN
  localparam logic [VID_BW-1:0] PAD_VAL = {VID_BW{1'b1}};
`else
  localparam logic [VID_BW-1:0] PAD_VAL = '0;
`endif

  logic [LANE_W-1:0]   lane_cnt;
  logic [VID_BW*Q-1:0] row_buf;
  logic [VID_BW*Q-1:0] row_merged;

  // Current buffer with the incoming ID dropped into its lane, so a commit sees the complete row.
  always_comb begin
    row_merged = row_buf;
    row_merged[VID_BW*lane_cnt +: VID_BW] = in_vid;
  end

  assign row    = row_merged;
  assign commit = fire && ((lane_cnt == LANE_W'(Q - 1)) || in_last) && en_clk_unused_guard_n;

  // Lane fill; a commit restarts at lane 0 with a pad-filled buffer for full-rate back-to-back rows.
  always_ff @(posedge clk) begin
    if (rst || commit) begin
      lane_cnt <= '0;
      row_buf  <= {Q{PAD_VAL}};
    end else if (fire) begin
      lane_cnt <= lane_cnt + 1'b1;
      row_buf  <= row_merged;
    end
  end

endmodule

// File: rtl/vid_pack_writer.sv
// Streams vertex IDs into packed SRAM rows at consecutive addresses, then handshakes batch completion.
// Latency: final ID accepted at t -> wsb low at t+1 -> batch_done pulse at t+2.
// Backpressure: in_ready drops from batch-end commit until batch_ack; no address wrap within a batch.
// Build option VID_PACK_PAD_EN selects the pad value of partial rows (all-ones vs zero).
module vid_pack_writer
  import vid_pkg::*;
#(
  parameter int ADDR_SPACE = ADDR_SPACE_DEF,
  parameter int Q          = Q_DEF,
  parameter int VID_BW     = VID_BW_DEF,
  parameter int NUM_ROWS   = NUM_ROWS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VID_BW-1:0]     in_vid,
  input  logic                  in_last,
  output logic                  wsb,
  output logic [ADDR_SPACE-1:0] waddr,
  output logic [VID_BW*Q-1:0]   wdata,
  output logic                  batch_done,
  output logic [ADDR_SPACE:0]   rows_written,
  input  logic                  batch_ack
);

  localparam logic [ADDR_SPACE:0] ROW_LAST = (ADDR_SPACE + 1)'(NUM_ROWS - 1);

  wr_state_t             state;
  logic [ADDR_SPACE:0]   row_ptr;
  logic                  fire;
  logic                  commit;
  logic                  batch_end;
  logic [VID_BW*Q-1:0]   row;

  assign fire         = in_valid && in_ready;
  assign batch_end    = in_last || (row_ptr == ROW_LAST);
  assign rows_written = row_ptr;

  vid_row_packer #(
    .Q      (Q),
    .VID_BW (VID_BW)
  ) u_packer (
    .en_clk_unused_guard_n (1'b1),
    .clk                   (clk),
    .rst                   (rst),
    .fire                  (fire),
    .in_vid                (in_vid),
    .in_last               (in_last),
    .row                   (row),
    .commit                (commit)
  );

  // Batch FSM plus registered SRAM write port; wsb is a single-cycle low per committed row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      in_ready   <= 1'b1;
      wsb        <= 1'b1;
      waddr      <= '0;
      wdata      <= '0;
      batch_done <= 1'b0;
      row_ptr    <= '0;
    end else begin
      wsb        <= 1'b1;
      batch_done <= 1'b0;
      if (commit) begin
        wsb   <= 1'b0;
        waddr <= row_ptr[ADDR_SPACE-1:0];
        wdata <= row;
      end
      if (!wsb) begin
        row_ptr <= row_ptr + 1'b1;
      end
      case (state)
        ST_FILL: begin
          if (commit && batch_end) begin
            state    <= ST_FLUSH;
            in_ready <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state      <= ST_WAIT_ACK;
          batch_done <= 1'b1;
        end
        ST_WAIT_ACK: begin
          if (batch_ack) begin
            state    <= ST_FILL;
            in_ready <= 1'b1;
            row_ptr  <= '0;
          end
        end
        default: begin
          state    <= ST_FILL;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
